spmv_col_fetch: RTL and testbench
=================================

Name: spmv_col_fetch

Overview:
Per-kernel AXI4 read master that streams one job of column-index data out of an HBM channel into the SpMV compute kernel. Sits directly downstream of the HBM Col port (one instance per kernel inside spmv_calc_top) and upstream of the kernel's index consumer. Splits a job into 4 KB-safe INCR bursts, keeps several bursts in flight and buffers read data in a FIFO. The FIFO space is reserved before each burst is issued, so R is never back-pressured by the stream side.

Parameters:
ADDR_WIDTH, 48, AXI byte address width
DATA_WIDTH, 256, AXI and stream data width; beat = DATA_WIDTH/8 = 32 bytes
MAX_BURST, 64, maximum beats per AR burst (1..256)
MAX_OUTSTANDING, 4, maximum ARs accepted but not fully returned
FIFO_DEPTH, 512, read data FIFO entries (power of 2, >= MAX_BURST)

Ports:
axis_clk  in  1  single clock for all logic
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle job request, sampled only when busy=0
base_addr  in  ADDR_WIDTH  job byte address; bits [4:0] forced to 0
len_beats  in  32  job length in beats
busy  out  1  job in progress
done  out  1  one-cycle pulse at job completion
m_axi_arvalid/arready  out/in  1  AR handshake
m_axi_araddr  out  ADDR_WIDTH  burst address
m_axi_arlen  out  8  beats-1
m_axi_arsize  out  3  constant 3'd5
m_axi_arburst  out  2  constant 2'b01 (INCR)
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready
m_axi_rdata  in  DATA_WIDTH  read data
m_axi_rlast  in  1  last beat of burst
m_axi_rresp  in  2  read response
m_axis_tvalid/tready  out/in  1  output stream handshake
m_axis_tdata  out  DATA_WIDTH  column-index beat
m_axis_tlast  out  1  final beat of job

Behaviour:
- Clocking and reset: one clock, axis_clk. rst is asynchronous and active-high.
- Values while rst is asserted: busy=0, done=0, arvalid=0, rready=0, tvalid=0, tlast=0, FIFO empty, all counters 0, state IDLE.
- Reset mid-job: everything is aborted immediately. The HBM slave is reset in the same cycle. In-flight R beats are not drained.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on start with len_beats>0, latch addr and rem=len_beats, then go to ISSUE. busy=1 from the next cycle.
- IDLE: on start with len_beats=0, go to DONE. No AR is issued.
- Burst size: beats = min(rem, MAX_BURST, (4096 - addr[11:0])/32). It is computed registered, so arvalid rises at the earliest 1 cycle after start.
- AR issue condition: all of the following must hold.
  - outstanding < MAX_OUTSTANDING
  - FIFO_DEPTH - (fifo_count + reserved_beats) >= beats
- On arvalid&&arready:
  - addr += beats*32 and rem -= beats
  - reserved_beats += beats and outstanding++
  - when rem reaches 0, go to DRAIN
- arvalid stays high, with araddr/arlen stable, until arready.
- rready=1 whenever busy. Reservation guarantees the FIFO cannot overflow.
- Each R beat: push rdata into the FIFO and decrement reserved_beats. On rlast, decrement outstanding.
- Simultaneous AR accept and R beat in one cycle: the counters net correctly; both updates apply.
- FIFO is first-word-fall-through. A beat accepted in cycle N is presented on tvalid in cycle N+1.
- tlast=1 on the beat whose popped count equals len_beats.
- DRAIN: when the tlast beat is accepted (tvalid&&tready), go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- start while busy=1 is ignored.
- rresp is ignored unless the optional feature is compiled in.
- Counter widths: rem and pop counters are 32 bits. reserved_beats and fifo_count are log2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: COL_FETCH_ERR_STAT_EN
- Defined: adds output err_cnt [15:0], which counts R beats with rresp!=0.
  - Saturates at 16'hFFFF.
  - Cleared on rst and on accepted start.
  - Erroneous data is still forwarded.
- Undefined: no err_cnt port. rresp is unused.

Test Plan:
- Single burst: base 0x1000, len 4, tready=1 -> one AR araddr=0x1000 arlen=3; 4 stream beats with tlast on the 4th; done pulses once.
- 4 KB split: base 0x0FC0, len 8 -> AR 0x0FC0 arlen=1, then AR 0x1000 arlen=5; 8 beats in address order.
- Long job: base 0, len 150 -> ARs arlen 63, 63, 21 at 0x0, 0x800, 0x1000; at most 4 outstanding; tlast only on beat 150.
- Backpressure: len 1000, tready=0 -> ARs stop once reserved plus buffered beats reach 512. Release tready -> all 1000 beats arrive in order, no loss, rready never drops data.
- Zero length: start with len 0 -> done 1 cycle later, arvalid never asserted, no tvalid.
- Reset mid-job: assert rst during the second burst -> all outputs 0 within the same cycle; then a new job with len 4 completes normally. With COL_FETCH_ERR_STAT_EN, inject rresp=2 on 3 beats -> err_cnt=3.

Source files
------------

// File: rtl/spmv_col_fetch_if.sv
// spmv_col_fetch_if: AXI4 read-address/read-data channels plus the AXI-Stream output
// of one column-index fetcher; master is the fetcher's view, slave the HBM/consumer view.
interface spmv_col_fetch_if #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 256
);
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic                  m_axi_rlast;
    logic [1:0]            m_axi_rresp;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tlast;
    modport master (
        output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        input  m_axi_arready,
        input  m_axi_rvalid, m_axi_rdata, m_axi_rlast, m_axi_rresp,
        output m_axi_rready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tlast,
        input  m_axis_tready
    );
    modport slave (
        input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        output m_axi_arready,
        output m_axi_rvalid, m_axi_rdata, m_axi_rlast, m_axi_rresp,
        input  m_axi_rready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/spmv_col_fetch.sv
// spmv_col_fetch: AXI4 read master splitting a job into 4 KB-safe bursts into a reserved FWFT FIFO.
// Defining COL_FETCH_ERR_STAT_EN adds err_cnt, a saturating count of R beats with rresp!=0.
module spmv_col_fetch #(
    parameter int ADDR_WIDTH      = 48,
    parameter int DATA_WIDTH      = 256,
    parameter int MAX_BURST       = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int FIFO_DEPTH      = 512
) (
    input  logic                  axis_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [31:0]           len_beats,
    output logic                  busy,
    output logic                  done,
`ifdef COL_FETCH_ERR_STAT_EN
    output logic [15:0]           err_cnt,
`endif
    spmv_col_fetch_if.master      bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           rem_q, rem_d, len_q, len_d, pop_q, pop_d;
    logic [8:0]            beats_q, beats_d, cap;
    logic [7:0]            page_beats;
    logic [CW-1:0]         resv_q, resv_d, fcnt_q, fcnt_d;
    logic [OW-1:0]         outst_q, outst_d;
    logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  start_ok, can_issue, arv, ar_acc, push, tv, tl, pop;
    logic                  unused_base;
    assign unused_base = ^base_addr[4:0];
    // Space is claimed at AR time, so every returning R beat already owns a FIFO slot.
    always_comb begin
        start_ok   = state_q == IDLE && start;
        busy       = state_q == ISSUE || state_q == DRAIN;
        done       = state_q == DONE;
        can_issue  = outst_q < OW'(MAX_OUTSTANDING) &&
                     (CW+1)'(fcnt_q) + (CW+1)'(resv_q) + (CW+1)'(beats_q) <= (CW+1)'(FIFO_DEPTH);
        arv        = state_q == ISSUE && can_issue;
        ar_acc     = arv && bus.m_axi_arready;
        push       = busy && bus.m_axi_rvalid;
        tv         = busy && fcnt_q != '0;
        tl         = tv && pop_q + 32'd1 == len_q;
        pop        = tv && bus.m_axis_tready;
        addr_d     = start_ok ? {base_addr[ADDR_WIDTH-1:5], 5'd0} :
                     ar_acc ? addr_q + (ADDR_WIDTH'(beats_q) << 5) : addr_q;
        rem_d      = start_ok ? len_beats : ar_acc ? rem_q - 32'(beats_q) : rem_q;
        len_d      = start_ok ? len_beats : len_q;
        pop_d      = start_ok ? '0 : pop ? pop_q + 32'd1 : pop_q;
        page_beats = 8'd128 - {1'b0, addr_d[11:5]};
        cap        = rem_d < 32'(MAX_BURST) ? rem_d[8:0] : 9'(MAX_BURST);
        beats_d    = cap > {1'b0, page_beats} ? {1'b0, page_beats} : cap;
        resv_d     = resv_q + (ar_acc ? CW'(beats_q) : CW'(0)) - CW'(push);
        outst_d    = outst_q + OW'(ar_acc) - OW'(push && bus.m_axi_rlast);
        fcnt_d     = fcnt_q + CW'(push) - CW'(pop);
        wr_d       = wr_q + PW'(push);
        rd_d       = rd_q + PW'(pop);
        state_d    = state_q;
        if (start_ok) state_d = len_beats == 32'd0 ? DONE : ISSUE;
        if (ar_acc && rem_d == 32'd0) state_d = DRAIN;
        if (state_q == DRAIN && pop && tl) state_d = DONE;
        if (state_q == DONE) state_d = IDLE;
    end
    always_ff @(posedge axis_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            len_q   <= '0;
            pop_q   <= '0;
            beats_q <= '0;
            resv_q  <= '0;
            fcnt_q  <= '0;
            outst_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            pop_q   <= pop_d;
            beats_q <= beats_d;
            resv_q  <= resv_d;
            fcnt_q  <= fcnt_d;
            outst_q <= outst_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end
    always_ff @(posedge axis_clk) begin
        if (push) mem_q[wr_q] <= bus.m_axi_rdata;
    end
    assign bus.m_axi_arvalid = arv;
    assign bus.m_axi_araddr  = addr_q;
    assign bus.m_axi_arlen   = 8'(beats_q - 9'd1);
    assign bus.m_axi_arsize  = 3'd5;
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_rready  = busy;
    assign bus.m_axis_tvalid = tv;
    assign bus.m_axis_tdata  = mem_q[rd_q];
    assign bus.m_axis_tlast  = tl;
`ifdef COL_FETCH_ERR_STAT_EN
    logic [15:0] err_q, err_d;
    always_comb begin
        err_d = start_ok ? 16'd0 :
                push && bus.m_axi_rresp != 2'b00 && err_q != 16'hFFFF ? err_q + 16'd1 : err_q;
    end
    always_ff @(posedge axis_clk or posedge rst) begin
        if (rst) err_q <= '0;
        else err_q <= err_d;
    end
    assign err_cnt = err_q;
`else
    logic unused_rresp;
    assign unused_rresp = ^bus.m_axi_rresp;
`endif
endmodule

// File: tb/tb_spmv_col_fetch.sv
// tb_spmv_col_fetch: directed bench with an in-order AXI read slave whose data encodes the beat
// address, so stream order is checkable against hand-computed addresses.
module tb_spmv_col_fetch;
    logic        clk = 1'b0;
    logic        rst, start, busy, done;
    logic [47:0] base_addr;
    logic [31:0] len_beats;
`ifdef COL_FETCH_ERR_STAT_EN
    logic [15:0] err_cnt;
`endif
    int tests = 0;
    int fails = 0;
    spmv_col_fetch_if #(.ADDR_WIDTH(48), .DATA_WIDTH(256)) bus ();
    spmv_col_fetch dut (
        .axis_clk (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .len_beats(len_beats),
        .busy     (busy),
        .done     (done),
`ifdef COL_FETCH_ERR_STAT_EN
        .err_cnt  (err_cnt),
`endif
        .bus      (bus)
    );
    always #5 clk = ~clk;
    logic [47:0]  ar_addr_log[$];
    logic [7:0]   ar_len_log[$];
    logic [255:0] t_data_log[$];
    logic         t_last_log[$];
    logic [47:0]  b_addr[$];
    logic [7:0]   b_len[$];
    int           beat, outst, max_outst, r_cnt, done_cnt, inj_err;
    logic         ar_seen, t_seen, r_en;
    logic         ar_hs, r_hs, r_err, t_hs, t_l;
    logic [47:0]  ar_a;
    logic [7:0]   ar_l;
    logic [255:0] t_d;
    function automatic logic [255:0] pat(input logic [47:0] a);
        return {32'hC01DDA7A, 176'd0, a};
    endfunction
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask
    task automatic clear_logs();
        ar_addr_log.delete();
        ar_len_log.delete();
        t_data_log.delete();
        t_last_log.delete();
        r_cnt = 0;
        done_cnt = 0;
        max_outst = outst;
        ar_seen = 1'b0;
        t_seen = 1'b0;
    endtask
    task automatic go(input logic [47:0] a, input logic [31:0] l);
        base_addr = a;
        len_beats = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic wait_done(input int lim);
        int n = 0;
        while (done_cnt == 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("done_within_budget", 64'(done_cnt != 0), 64'd1);
        repeat (3) @(negedge clk);
    endtask
    task automatic check_stream(input string tag, input logic [47:0] base, input int n);
        int bad = 0;
        int lbad = 0;
        chk({tag, "_count"}, 64'(t_data_log.size()), 64'(n));
        foreach (t_data_log[i]) begin
            if (t_data_log[i] !== pat(base + 48'(i) * 48'd32)) bad++;
            if (t_last_log[i] !== (i == n - 1)) lbad++;
        end
        chk({tag, "_data_order"}, 64'(bad), 64'd0);
        chk({tag, "_tlast"}, 64'(lbad), 64'd0);
    endtask
    // Handshakes are sampled mid-cycle (stable until the next edge) and applied just after it.
    always begin
        @(negedge clk);
        ar_hs = bus.m_axi_arvalid && bus.m_axi_arready;
        ar_a  = bus.m_axi_araddr;
        ar_l  = bus.m_axi_arlen;
        r_hs  = bus.m_axi_rvalid && bus.m_axi_rready;
        r_err = bus.m_axi_rresp != 2'b00;
        t_hs  = bus.m_axis_tvalid && bus.m_axis_tready;
        t_d   = bus.m_axis_tdata;
        t_l   = bus.m_axis_tlast;
        if (done) done_cnt++;
        if (bus.m_axi_arvalid) ar_seen = 1'b1;
        if (bus.m_axis_tvalid) t_seen = 1'b1;
        @(posedge clk);
        #1;
        if (rst) begin
            b_addr.delete();
            b_len.delete();
            beat = 0;
            outst = 0;
        end else begin
            if (ar_hs) begin
                ar_addr_log.push_back(ar_a);
                ar_len_log.push_back(ar_l);
                b_addr.push_back(ar_a);
                b_len.push_back(ar_l);
                outst++;
                if (outst > max_outst) max_outst = outst;
            end
            if (r_hs) begin
                r_cnt++;
                if (r_err && inj_err > 0) inj_err--;
                if (beat == int'(b_len[0])) begin
                    void'(b_addr.pop_front());
                    void'(b_len.pop_front());
                    beat = 0;
                    outst--;
                end else beat++;
            end
            if (t_hs) begin
                t_data_log.push_back(t_d);
                t_last_log.push_back(t_l);
            end
        end
        bus.m_axi_rvalid = r_en && b_addr.size() != 0;
        bus.m_axi_rdata  = '0;
        bus.m_axi_rlast  = 1'b0;
        bus.m_axi_rresp  = 2'b00;
        if (bus.m_axi_rvalid) begin
            bus.m_axi_rdata = pat(b_addr[0] + 48'(beat) * 48'd32);
            bus.m_axi_rlast = beat == int'(b_len[0]);
            bus.m_axi_rresp = inj_err > 0 ? 2'b10 : 2'b00;
        end
    end
    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        len_beats = '0;
        bus.m_axi_arready = 1'b1;
        bus.m_axis_tready = 1'b1;
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rdata = '0;
        bus.m_axi_rlast = 1'b0;
        bus.m_axi_rresp = 2'b00;
        r_en = 1'b1;
        inj_err = 0;
        beat = 0;
        outst = 0;
        clear_logs();
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({busy, done, bus.m_axi_arvalid, bus.m_axi_rready,
                                  bus.m_axis_tvalid, bus.m_axis_tlast}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        // Single burst; low address bits must be dropped.
        clear_logs();
        go(48'h1007, 4);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_arvalid", 64'(bus.m_axi_arvalid), 64'd1);
        chk("t1_araddr", 64'(bus.m_axi_araddr), 64'h1000);
        chk("t1_arlen", 64'(bus.m_axi_arlen), 64'd3);
        chk("t1_arsize", 64'(bus.m_axi_arsize), 64'd5);
        chk("t1_arburst", 64'(bus.m_axi_arburst), 64'd1);
        wait_done(200);
        chk("t1_ar_count", 64'(ar_addr_log.size()), 64'd1);
        check_stream("t1", 48'h1000, 4);
        chk("t1_done_once", 64'(done_cnt), 64'd1);
        chk("t1_idle", 64'(busy), 64'd0);
        // 4 KB split with AR held off for a few cycles.
        clear_logs();
        bus.m_axi_arready = 1'b0;
        go(48'h0FC0, 8);
        repeat (2) @(negedge clk);
        chk("t2_arvalid_held", 64'(bus.m_axi_arvalid), 64'd1);
        chk("t2_araddr_held", 64'(bus.m_axi_araddr), 64'h0FC0);
        chk("t2_arlen_held", 64'(bus.m_axi_arlen), 64'd1);
        bus.m_axi_arready = 1'b1;
        wait_done(200);
        chk("t2_ar_count", 64'(ar_addr_log.size()), 64'd2);
        chk("t2_ar0_addr", 64'(ar_addr_log[0]), 64'h0FC0);
        chk("t2_ar1_addr", 64'(ar_addr_log[1]), 64'h1000);
        chk("t2_ar1_len", 64'(ar_len_log[1]), 64'd5);
        check_stream("t2", 48'h0FC0, 8);
        // Long job: 64 + 64 + 22 beats.
        clear_logs();
        go(48'h0, 150);
        wait_done(1000);
        chk("t3_ar_count", 64'(ar_addr_log.size()), 64'd3);
        chk("t3_ar1_addr", 64'(ar_addr_log[1]), 64'h0800);
        chk("t3_ar2_addr", 64'(ar_addr_log[2]), 64'h1000);
        chk("t3_ar0_len", 64'(ar_len_log[0]), 64'd63);
        chk("t3_ar2_len", 64'(ar_len_log[2]), 64'd21);
        chk("t3_max_outst", 64'(max_outst <= 4), 64'd1);
        check_stream("t3", 48'h0, 150);
        // Backpressure: outstanding cap first, then FIFO reservation cap.
        clear_logs();
        r_en = 1'b0;
        bus.m_axis_tready = 1'b0;
        go(48'h0, 1000);
        repeat (30) @(negedge clk);
        chk("t4_ar_outst_cap", 64'(ar_addr_log.size()), 64'd4);
        chk("t4_max_outst", 64'(max_outst), 64'd4);
        r_en = 1'b1;
        repeat (700) @(negedge clk);
        chk("t4_ar_fifo_cap", 64'(ar_addr_log.size()), 64'd8);
        chk("t4_r_beats", 64'(r_cnt), 64'd512);
        chk("t4_no_pop", 64'(t_data_log.size()), 64'd0);
        chk("t4_rready", 64'(bus.m_axi_rready), 64'd1);
        chk("t4_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
        bus.m_axis_tready = 1'b1;
        wait_done(3000);
        chk("t4_ar_count", 64'(ar_addr_log.size()), 64'd16);
        chk("t4_last_addr", 64'(ar_addr_log[15]), 64'h7800);
        chk("t4_last_len", 64'(ar_len_log[15]), 64'd39);
        check_stream("t4", 48'h0, 1000);
        // Zero length.
        clear_logs();
        go(48'h3000, 0);
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        chk("t5_done_once", 64'(done_cnt), 64'd1);
        chk("t5_no_arvalid", 64'(ar_seen), 64'd0);
        chk("t5_no_tvalid", 64'(t_seen), 64'd0);
        // Reset during the second burst, then a fresh job with injected error responses.
        clear_logs();
        go(48'h0, 300);
        n = 0;
        while (r_cnt < 70 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t6_in_burst2", 64'(r_cnt >= 70), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_reset_outputs", 64'({busy, done, bus.m_axi_arvalid, bus.m_axi_rready,
                                     bus.m_axis_tvalid, bus.m_axis_tlast}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        inj_err = 3;
        go(48'h2000, 4);
        wait_done(200);
        chk("t6_ar_count", 64'(ar_addr_log.size()), 64'd1);
        check_stream("t6", 48'h2000, 4);
`ifdef COL_FETCH_ERR_STAT_EN
        chk("t6_err_cnt", 64'(err_cnt), 64'd3);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
